// File: rtl/axi4_write_dma.sv
// AXI4 write DMA: packs AXI-Stream words into AXI beats and writes them
// to memory in INCR bursts, one outstanding burst at a time.
module axi4_write_dma #(
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int MAX_BURST_LEN   = 256
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   start_addr,
    input  logic [31:0]                 transfer_length,
    input  logic                        start,
    output logic                        done,
    output logic                        error,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready
);

    localparam int WPB        = AXI_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int WIDX_W     = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int WORD_BYTES = AXIS_DATA_WIDTH / 8;
    localparam logic [2:0] AWSIZE = 3'($clog2(BEAT_BYTES));

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_AW,
        COLLECT,
        SEND_W,
        WAIT_B,
        DONE_STATE
    } state_t;

    state_t state, state_nx;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               rem_q;
    logic [31:0]               words_q;
    logic [31:0]               total_words_q;
    logic [7:0]                beat_q;
    logic [WIDX_W-1:0]         widx_q;
    logic [AXI_DATA_WIDTH-1:0] buf_q;
    logic                      err_q;

    logic [31:0] beats_rem;
    logic [31:0] burst_beats;
    logic [31:0] burst_bytes;
    logic [7:0]  awlen_c;
    logic        last_word;
    logic        last_beat;
    logic        t_fire;
    logic        w_fire;
    logic        b_fire;
    logic        unused_ok;

    // Burst size is derived from the remaining byte count, which only
    // changes on a B handshake, so it is stable for the whole burst.
    assign beats_rem   = rem_q / 32'(BEAT_BYTES);
    assign burst_beats = (beats_rem > 32'(MAX_BURST_LEN)) ?
                         32'(MAX_BURST_LEN) : beats_rem;
    assign burst_bytes = burst_beats * 32'(BEAT_BYTES);
    assign awlen_c     = 8'(burst_beats - 32'd1);

    assign last_word = (widx_q == WIDX_W'(WPB - 1));
    assign last_beat = (beat_q == awlen_c);
    assign t_fire    = (state == COLLECT) && s_axis_tvalid;
    assign w_fire    = (state == SEND_W) && m_axi_wready;
    assign b_fire    = (state == WAIT_B) && m_axi_bvalid;
    assign unused_ok = ^m_axi_bid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (transfer_length == 32'd0) ?
                               DONE_STATE : ISSUE_AW;
                end
            end
            ISSUE_AW: begin
                if (m_axi_awready) state_nx = COLLECT;
            end
            COLLECT: begin
                if (t_fire && last_word) state_nx = SEND_W;
            end
            SEND_W: begin
                if (m_axi_wready) begin
                    state_nx = last_beat ? WAIT_B : COLLECT;
                end
            end
            WAIT_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00 || rem_q <= burst_bytes) begin
                        state_nx = DONE_STATE;
                    end else begin
                        state_nx = ISSUE_AW;
                    end
                end
            end
            DONE_STATE: begin
                if (!start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done          = 1'b0;
        error         = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        s_axis_tready = 1'b0;
        unique case (state)
            ISSUE_AW:   m_axi_awvalid = 1'b1;
            COLLECT:    s_axis_tready = 1'b1;
            SEND_W: begin
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = last_beat;
            end
            WAIT_B:     m_axi_bready = 1'b1;
            DONE_STATE: begin
                done  = 1'b1;
                error = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q        <= '0;
            rem_q         <= '0;
            words_q       <= '0;
            total_words_q <= '0;
            beat_q        <= '0;
            widx_q        <= '0;
            buf_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                addr_q        <= start_addr;
                rem_q         <= transfer_length;
                words_q       <= '0;
                total_words_q <= transfer_length / 32'(WORD_BYTES);
                beat_q        <= '0;
                widx_q        <= '0;
                err_q         <= 1'b0;
            end
            if (t_fire) begin
                for (int i = 0; i < WPB; i++) begin
                    if (widx_q == WIDX_W'(i)) begin
                        buf_q[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= s_axis_tdata;
                    end
                end
                widx_q  <= last_word ? '0 : widx_q + 1'b1;
                words_q <= words_q + 32'd1;
                // tlast must mark exactly the final word of the transfer
                if (s_axis_tlast != (words_q == total_words_q - 32'd1)) begin
                    err_q <= 1'b1;
                end
            end
            if (w_fire) begin
                beat_q <= last_beat ? '0 : beat_q + 8'd1;
            end
            if (b_fire) begin
                if (m_axi_bresp != 2'b00) begin
                    err_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + AXI_ADDR_WIDTH'(burst_bytes);
                    rem_q  <= rem_q - burst_bytes;
                end
            end
        end
    end

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_c;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_wdata   = buf_q;
    assign m_axi_wstrb   = '1;

endmodule

// File: tb/tb_axi4_write_dma.sv
// Randomized bench for axi4_write_dma against a transfer-level model of
// the expected AW bursts, W beats and error flag.
module tb_axi4_write_dma;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [63:0]   start_addr;
    logic [31:0]   transfer_length;
    logic          start;
    logic          done;
    logic          error;
    logic [0:0]    m_axi_awid;
    logic [63:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awlock;
    logic [3:0]    m_axi_awcache;
    logic [2:0]    m_axi_awprot;
    logic [3:0]    m_axi_awqos;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [127:0]  m_axi_wdata;
    logic [15:0]   m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [0:0]    m_axi_bid;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;

    always #5 aclk = ~aclk;

    axi4_write_dma dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .start_addr      (start_addr),
        .transfer_length (transfer_length),
        .start           (start),
        .done            (done),
        .error           (error),
        .m_axi_awid      (m_axi_awid),
        .m_axi_awaddr    (m_axi_awaddr),
        .m_axi_awlen     (m_axi_awlen),
        .m_axi_awsize    (m_axi_awsize),
        .m_axi_awburst   (m_axi_awburst),
        .m_axi_awlock    (m_axi_awlock),
        .m_axi_awcache   (m_axi_awcache),
        .m_axi_awprot    (m_axi_awprot),
        .m_axi_awqos     (m_axi_awqos),
        .m_axi_awvalid   (m_axi_awvalid),
        .m_axi_awready   (m_axi_awready),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wlast     (m_axi_wlast),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_bid       (m_axi_bid),
        .m_axi_bresp     (m_axi_bresp),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]  src_words[$];
    int           src_idx = 0;
    int           src_n = 0;
    int           src_tlast = -1;
    bit           stall_mode = 0;
    int           bad_burst = -1;
    int           b_idx = 0;
    int           aw_cnt = 0;
    int           b_cnt = 0;
    logic [63:0]  aw_addr_q[$];
    logic [7:0]   aw_len_q[$];
    logic [127:0] w_data_q[$];
    bit           w_last_q[$];
    bit           w_stalled = 0;
    logic [127:0] w_held;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // AXI-Stream source; may drop tvalid between words
    initial begin
        bit fire;
        s_axis_tvalid = 0;
        s_axis_tdata  = 0;
        s_axis_tlast  = 0;
        forever begin
            @(negedge aclk);
            fire = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (fire) src_idx++;
            if (src_idx < src_n) begin
                s_axis_tvalid = ($urandom % 4) != 0;
                s_axis_tdata  = src_words[src_idx];
                s_axis_tlast  = (src_idx == src_tlast);
            end else begin
                s_axis_tvalid = 0;
                s_axis_tlast  = 0;
            end
        end
    end

    initial begin
        m_axi_awready = 0;
        forever begin
            @(posedge aclk);
            #1;
            m_axi_awready = ($urandom % 3) != 0;
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        m_axi_wready = 0;
        forever begin
            @(negedge aclk);
            if (m_axi_wvalid) cnt = m_axi_wready ? 0 : cnt + 1;
            @(posedge aclk);
            #1;
            m_axi_wready = stall_mode ? (cnt >= 5) : (($urandom % 4) != 0);
        end
    end

    initial begin
        bit ok;
        m_axi_bvalid = 0;
        m_axi_bresp  = 0;
        m_axi_bid    = 0;
        forever begin
            @(negedge aclk);
            if (aresetn && m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
                m_axi_bresp  = (b_idx == bad_burst) ? 2'b10 : 2'b00;
                m_axi_bvalid = 1;
                ok = 0;
                for (int k = 0; k < 200 && !ok; k++) begin
                    @(negedge aclk);
                    ok = m_axi_bready;
                end
                @(posedge aclk);
                #1;
                m_axi_bvalid = 0;
                m_axi_bresp  = 0;
                b_idx++;
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (s_axis_tready && m_axi_wvalid) chk("tready_wvalid_excl", 1, 0);
            if (m_axi_awvalid && m_axi_awready) begin
                chk("aw_one_outstanding", aw_cnt - b_cnt, 0);
                chk("aw_attr", {m_axi_awid, m_axi_awsize, m_axi_awburst,
                                m_axi_awlock, m_axi_awcache, m_axi_awprot,
                                m_axi_awqos},
                    {1'b0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
                aw_addr_q.push_back(m_axi_awaddr);
                aw_len_q.push_back(m_axi_awlen);
                aw_cnt++;
            end
            if (m_axi_bvalid && m_axi_bready) b_cnt++;
            if (m_axi_wvalid && m_axi_wready) begin
                chk("wstrb", m_axi_wstrb, 16'hffff);
                w_data_q.push_back(m_axi_wdata);
                w_last_q.push_back(m_axi_wlast);
            end
            if (w_stalled) begin
                chk("w_hold_valid", m_axi_wvalid, 1);
                chk("w_hold_data", m_axi_wdata, w_held);
            end
            w_stalled = m_axi_wvalid && !m_axi_wready;
            w_held    = m_axi_wdata;
        end else begin
            w_stalled = 0;
        end
    end

    task automatic reset_dut();
        @(negedge aclk);
        aresetn = 0;
        start   = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1;
        src_n   = 0;
        src_idx = 0;
    endtask

    task automatic load_src(input int nw, input int tl_pos, input bit seq);
        src_words.delete();
        for (int i = 0; i < nw; i++) begin
            src_words.push_back(seq ? 32'(i) : $urandom);
        end
        src_idx   = 0;
        src_n     = nw;
        src_tlast = tl_pos;
    endtask

    task automatic run(input logic [63:0] addr, input int len,
                       input int tl_pos, input int bad,
                       input bit stall, input bit seq);
        int          nw;
        int          rem;
        int          bi;
        int          consumed;
        bit          eerr;
        bit          got;
        logic [63:0] a;
        logic [63:0] ea[$];
        int          el[$];
        bit          elast[$];
        logic [127:0] eb;

        nw = len / 4;
        @(negedge aclk);
        load_src(nw, tl_pos, seq);
        bad_burst  = bad;
        b_idx      = 0;
        stall_mode = stall;
        aw_cnt     = 0;
        b_cnt      = 0;
        aw_addr_q.delete();
        aw_len_q.delete();
        w_data_q.delete();
        w_last_q.delete();

        // reference: split into <=256-beat bursts, stop after a bad B
        rem = len;
        a = addr;
        bi = 0;
        consumed = 0;
        eerr = 0;
        while (rem > 0) begin
            int beats;
            beats = rem / 16;
            if (beats > 256) beats = 256;
            ea.push_back(a);
            el.push_back(beats - 1);
            for (int k = 0; k < beats; k++) elast.push_back(k == beats - 1);
            consumed += beats * 4;
            if (bi == bad) begin
                eerr = 1;
                break;
            end
            a += 64'(beats * 16);
            rem -= beats * 16;
            bi++;
        end
        if (nw > 0 && tl_pos != nw - 1) eerr = 1;

        start_addr      = addr;
        transfer_length = len;
        start           = 1;
        got = 0;
        for (int c = 0; c < 30000 && !got; c++) begin
            @(negedge aclk);
            got = done;
        end
        chk("done_seen", got, 1);
        if (!got) begin
            reset_dut();
            return;
        end
        chk("error", error, eerr);
        chk("aw_count", aw_addr_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < aw_addr_q.size(); i++) begin
            chk("awaddr", aw_addr_q[i], ea[i]);
            chk("awlen", aw_len_q[i], el[i]);
        end
        chk("w_count", w_data_q.size(), consumed / 4);
        for (int j = 0; j < consumed / 4 && j < w_data_q.size(); j++) begin
            eb = {src_words[4*j+3], src_words[4*j+2],
                  src_words[4*j+1], src_words[4*j]};
            chk("wdata", w_data_q[j], eb);
            chk("wlast", w_last_q[j], elast[j]);
        end
        chk("words_consumed", src_idx, consumed);
        repeat (3) @(negedge aclk);
        chk("done_hold", done, 1);
        chk("no_retrigger", aw_cnt, ea.size());
        start = 0;
        @(negedge aclk);
        chk("idle_done", done, 0);
        chk("idle_error", error, 0);
    endtask

    initial begin
        bit got;
        aresetn         = 0;
        start           = 0;
        start_addr      = 0;
        transfer_length = 0;
        repeat (3) @(negedge aclk);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast,
                           m_axi_bready, s_axis_tready}, 5'b0);
        aresetn = 1;

        run(64'h1000, 64, 15, -1, 0, 1);
        chk("beat0", w_data_q[0],
            128'h00000003_00000002_00000001_00000000);
        run(64'h8000_0000, 8192, 2047, -1, 0, 0);
        run(64'h4000, 48, 11, -1, 1, 0);
        run(64'h1000, 8192, 2047, 0, 0, 0);
        run(64'h1000, 64, 7, -1, 0, 1);
        run(64'h3000, 64, -1, -1, 0, 0);
        run(64'h5000, 0, -1, -1, 0, 0);
        run(64'hFFFF_FFFF_FFFF_F000, 8192, 2047, -1, 0, 0);

        // reset while a beat is waiting in SEND_W
        @(negedge aclk);
        load_src(16, 15, 1);
        stall_mode      = 1;
        start_addr      = 64'h2000;
        transfer_length = 64;
        start           = 1;
        got = 0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge aclk);
            got = m_axi_wvalid;
        end
        chk("sendw_reached", got, 1);
        aresetn = 0;
        start   = 0;
        @(negedge aclk);
        chk("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast,
                              m_axi_bready, s_axis_tready}, 5'b0);
        chk("midrst_done", {done, error}, 2'b00);
        aresetn = 1;
        src_n   = 0;
        src_idx = 0;
        run(64'h2000, 64, 15, -1, 0, 0);

        for (int t = 0; t < 6; t++) begin
            int len;
            int nw;
            int tl;
            int bad;
            logic [63:0] addr;
            len  = 16 * $urandom_range(1, 600);
            nw   = len / 4;
            addr = {$urandom, $urandom} & ~64'hF;
            tl   = (($urandom % 5) == 0) ? $urandom_range(0, nw - 1) : nw - 1;
            bad  = (($urandom % 5) == 0) ?
                   $urandom_range(0, (nw / 4 - 1) / 256) : -1;
            run(addr, len, tl, bad, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_write_dma.md
AXI4_WRITE_DMA -- requirements
Module: axi4_write_dma

Interface
REQ-001 SHALL have parameters: AXI_ADDR_WIDTH, 64, AXI address width; AXI_DATA_WIDTH, 128, W beat width; AXI_ID_WIDTH, 1, ID width; AXIS_DATA_WIDTH, 32, input stream word width; MAX_BURST_LEN, 256, max beats per burst.
REQ-002 SHALL have ports (clock and reset first):
- aclk  in  1  clock.
- aresetn  in  1  reset: synchronous, active-low.
- start_addr  in  AXI_ADDR_WIDTH  DDR destination, 16-byte aligned.
- transfer_length  in  32  bytes to write, multiple of AXI_DATA_WIDTH/8.
- start  in  1  level request, sampled in IDLE.
- done  out  1  transfer finished.
- error  out  1  failure flag, valid while done=1.
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  ID/ADDR/8/3/2/1/4/3/4  AW channel.
- m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  AXI_DATA_WIDTH; m_axi_wstrb  out  AXI_DATA_WIDTH/8; m_axi_wlast  out  1; m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bid  in  ID; m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
- s_axis_tdata  in  AXIS_DATA_WIDTH; s_axis_tvalid  in  1; s_axis_tlast  in  1; s_axis_tready  out  1.

Function
REQ-003 SHALL implement states IDLE, ISSUE_AW, COLLECT, SEND_W, WAIT_B, DONE_STATE.
REQ-004 IDLE: done=0, error=0; on start=1 latch start_addr, transfer_length, clear word/beat counters; go ISSUE_AW; if transfer_length=0 go DONE_STATE directly.
REQ-005 ISSUE_AW: awlen = min(MAX_BURST_LEN, bytes_remaining/16)-1; awsize=log2(AXI_DATA_WIDTH/8); awburst=INCR; awcache=4'b0011; awid, awlock, awprot, awqos all 0; awvalid held until awready, then deasserted next cycle; go COLLECT.
REQ-006 COLLECT: s_axis_tready=1; each tvalid&tready word placed in lane word_index (word 0 in bits [31:0]); on 4th word (WORDS_PER_BEAT=AXI_DATA_WIDTH/AXIS_DATA_WIDTH) drop tready, go SEND_W.
REQ-007 SEND_W: wvalid=1, wstrb all ones, wlast=1 only on beat awlen of current burst; data stable until wready; after handshake go COLLECT if more beats in burst, else WAIT_B with bready=1.
REQ-008 s_axis_tready and m_axi_wvalid SHALL never both be 1; no AXIS word SHALL be accepted outside COLLECT.
REQ-009 WAIT_B: on bvalid&bready: bresp!=0 -> error=1, DONE_STATE; else awaddr += (awlen+1)*16, bytes_remaining -= (awlen+1)*16; remaining>0 -> ISSUE_AW, else DONE_STATE.
REQ-010 tlast SHALL be checked: tlast=1 on a word other than the final expected word, or tlast=0 on the final word, sets sticky error; data counting follows transfer_length only.
REQ-011 DONE_STATE: done=1, all valid/ready outputs 0; stays until start=0, then IDLE; start held high SHALL NOT retrigger.
REQ-012 start asserted outside IDLE SHALL be ignored.
REQ-013 Byte arithmetic SHALL be 32-bit unsigned; address addition AXI_ADDR_WIDTH bits, wraps without error.
REQ-014 Only one outstanding AW burst; next AW issued only after B of previous.

Reset
REQ-015 aresetn=0 at any clock edge SHALL, including mid-burst, force IDLE, done=0, error=0, awvalid=0, wvalid=0, wlast=0, bready=0, s_axis_tready=0, counters 0; partial beat discarded.

Verification
REQ-016 start_addr=0x1000, length=64, words 0..15, last tlast -> one AW awaddr=0x1000 awlen=3; 4 W beats, beat0=0x00000003_00000002_00000001_00000000, wlast on beat 3; BRESP OK -> done=1, error=0.
REQ-017 length=8192 -> two AWs: 0x...+0 awlen=255, +0x1000 awlen=255; second AW only after first B.
REQ-018 length=48, wready low 5 cycles per beat, tvalid toggling -> wdata stable while stalled, tready=0 in SEND_W, 12 words in exact order.
REQ-019 bresp=2'b10 on first burst of 8192 -> error=1, done=1, no second AW.
REQ-020 tlast on word 7 of 16 -> transfer completes 4 beats, error=1 at done; aresetn=0 during SEND_W -> wvalid=0 next cycle, IDLE, restart succeeds.
